// File: rtl/usb_pkg.sv
// Shared types and constants for the full-speed USB receiver.
`timescale 1ns/1ps
package usb_pkg;

  // Encoded as {dp, dn} so the synchroniser output maps directly.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_ABORT
  } rx_state_t;

  localparam int BIT_PERIOD          = 4;
  localparam int STUFF_LIMIT_DEFAULT = 6;

endpackage

// File: rtl/usb_line_sync.sv
// Two-flop synchroniser for D+/D- and line-state decode.
`timescale 1ns/1ps
module usb_line_sync
  import usb_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_dp,
  input  logic  i_dn,
  output line_t o_line
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;

  // Reset to J so an idle bus produces no phantom transition.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 2'b10;
      r_sync <= 2'b10;
    end else begin
      r_meta <= {i_dp, i_dn};
      r_sync <= r_meta;
    end
  end

  assign o_line = line_t'(r_sync);

endmodule

// File: rtl/usb_fs_rx.sv
// Full-speed USB receiver: phase recovery, NRZI decode,
// unstuffing, byte assembly and EOP/error detection.
`timescale 1ns/1ps
module usb_fs_rx
  import usb_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       dp,
  input  logic       dn,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_err
);

  localparam int PW = $clog2(BIT_PERIOD);
  localparam int OW = $clog2(STUFF_LIMIT + 1);

  line_t w_line;

  usb_line_sync u_sync (
    .i_clk  (clk48),
    .i_rst  (rst),
    .i_dp   (dp),
    .i_dn   (dn),
    .o_line (w_line)
  );

  rx_state_t     r_state, w_state;
  line_t         r_line_prev;
  logic [PW-1:0] r_phase, w_phase;
  logic          r_prev_j, w_prev_j;
  logic [2:0]    r_zeros, w_zeros;
  logic [OW-1:0] r_ones, w_ones;
  logic [2:0]    r_bits, w_bits;
  logic [7:0]    r_shift, w_shift;
  logic [1:0]    r_se0, w_se0;
  logic          r_jseen, w_jseen;
  logic [7:0]    r_data, w_data;
  logic          r_valid, w_valid;
  logic          r_eop, w_eop;
  logic          r_err, w_err;
  logic          w_jk, w_trans, w_sample, w_dbit;

  assign w_jk = (w_line == LS_J) || (w_line == LS_K);
  assign w_trans = w_jk && (w_line != r_line_prev) &&
                   ((r_line_prev == LS_J) || (r_line_prev == LS_K));
  // A sample never lands on the transition cycle itself.
  assign w_sample = (r_phase == PW'(1)) && !w_trans;
  assign w_dbit = ((w_line == LS_J) == r_prev_j);

  always_ff @(posedge clk48) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_line_prev <= LS_J;
      r_phase     <= '0;
      r_prev_j    <= 1'b1;
      r_zeros     <= '0;
      r_ones      <= '0;
      r_bits      <= '0;
      r_shift     <= '0;
      r_se0       <= '0;
      r_jseen     <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_eop       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_line_prev <= w_line;
      r_phase     <= w_phase;
      r_prev_j    <= w_prev_j;
      r_zeros     <= w_zeros;
      r_ones      <= w_ones;
      r_bits      <= w_bits;
      r_shift     <= w_shift;
      r_se0       <= w_se0;
      r_jseen     <= w_jseen;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_eop       <= w_eop;
      r_err       <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_phase  = w_trans ? '0 : r_phase + 1'b1;
    w_prev_j = r_prev_j;
    w_zeros  = r_zeros;
    w_ones   = r_ones;
    w_bits   = r_bits;
    w_shift  = r_shift;
    w_se0    = r_se0;
    w_jseen  = r_jseen;
    w_data   = r_data;
    w_valid  = 1'b0;
    w_eop    = 1'b0;
    w_err    = 1'b0;
    if (w_sample) begin
      if (w_jk) w_prev_j = (w_line == LS_J);
      if (r_state != S_ABORT) w_jseen = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_line == LS_K) begin
            w_state = S_SYNC;
            w_zeros = '0;
          end
        end
        S_SYNC: begin
          if (w_line == LS_SE1) begin
            w_state = S_ABORT;
            w_err   = 1'b1;
          end else if (w_line == LS_SE0) begin
            w_state = S_IDLE;
          end else if (!w_dbit) begin
            if (r_zeros != 3'd5) w_zeros = r_zeros + 1'b1;
          end else if (r_zeros == 3'd5) begin
            w_state = S_DATA;
            w_ones  = '0;
            w_bits  = '0;
            w_se0   = '0;
          end else begin
            w_state = S_IDLE;
          end
        end
        S_DATA: begin
          if (w_line == LS_SE1) begin
            w_state = S_ABORT;
            w_err   = 1'b1;
          end else if (w_line == LS_SE0) begin
            if (r_se0 != 2'd2) w_se0 = r_se0 + 1'b1;
          end else if (r_se0 != 2'd0) begin
            if ((r_se0 == 2'd2) && (w_line == LS_J)) begin
              w_state = S_IDLE;
              w_eop   = 1'b1;
              w_err   = (r_bits != 3'd0);
            end else begin
              w_state = S_ABORT;
              w_err   = 1'b1;
            end
          end else if (r_ones == OW'(STUFF_LIMIT)) begin
            w_ones = '0;
            if (w_dbit) begin
              w_state = S_ABORT;
              w_err   = 1'b1;
            end
          end else begin
            w_shift = {w_dbit, r_shift[7:1]};
            w_bits  = r_bits + 1'b1;
            w_ones  = w_dbit ? r_ones + 1'b1 : '0;
            if (r_bits == 3'd7) begin
              w_data  = {w_dbit, r_shift[7:1]};
              w_valid = 1'b1;
            end
          end
        end
        S_ABORT: begin
          if (w_line == LS_J) begin
            if (r_jseen) w_state = S_IDLE;
            w_jseen = 1'b1;
          end else begin
            w_jseen = 1'b0;
          end
        end
      endcase
    end
  end

  assign rx_active = (r_state == S_DATA);
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_eop    = r_eop;
  assign rx_err    = r_err;

endmodule

// File: doc/usb_fs_rx.md
USB_FS_RX -- requirements
Module: usb_fs_rx

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; both are listed first below.
REQ-002 SHALL provide the following ports:
- clk48  input  1  48 MHz system clock, 4x the full-speed bit rate.
- rst  input  1  synchronous active-high reset.
- dp  input  1  raw, asynchronous USB D+ line.
- dn  input  1  raw, asynchronous USB D- line.
- rx_active  output  1  high from the end of SYNC until the end of EOP or an abort.
- rx_data  output  8  received byte, LSB first on the wire.
- rx_valid  output  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_eop  output  1  one-cycle strobe at a completed EOP.
- rx_err  output  1  one-cycle strobe on a stuff error, SE1, or a partial byte at EOP.
REQ-003 SHALL use the following parameter:
- STUFF_LIMIT  default 6  number of consecutive decoded 1s after which a stuffed 0 is expected.

Function
REQ-004 SHALL pass dp and dn through a 2-flop synchroniser, then decode the line state: J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
REQ-005 SHALL run a 2-bit phase counter that is cleared on every synchronised J/K transition and otherwise increments modulo 4.
REQ-006 SHALL take the bit sample in the cycle where phase==1 (mid-bit); all decode steps advance only on sample cycles.
REQ-007 SHALL NRZI-decode each sampled bit: decoded bit = 1 if the sample equals the previous J/K sample, else 0.
REQ-008 SHALL implement the state machine IDLE, SYNC, DATA, ABORT:
- IDLE to SYNC on the first sampled K.
- SYNC to DATA after at least 5 decoded 0s followed by a decoded 1 (the KK pair); rx_active rises in that cycle.
- SYNC to IDLE on a decoded 1 before 5 zeros, or on SE0.
REQ-009 SHALL, in DATA, count consecutive decoded 1s and handle bit stuffing:
- After STUFF_LIMIT consecutive 1s, the next bit is discarded if it is 0.
- If that next bit is 1: pulse rx_err, go to ABORT, drop rx_active.
REQ-010 SHALL assemble non-stuffed bits LSB first; the 8th bit SHALL update rx_data and pulse rx_valid exactly 1 clk48 after its sample cycle.
REQ-011 SHALL detect EOP in DATA when SE0 is sampled on 2 consecutive bit samples followed by a J sample; it SHALL then pulse rx_eop, clear rx_active and return to IDLE.
REQ-012 SHALL, if EOP arrives with a nonzero partial bit count, pulse rx_err in the same cycle as rx_eop and discard the partial byte.
REQ-013 SHALL treat SE1 in any state other than IDLE as an error: pulse rx_err and go to ABORT.
REQ-014 SHALL leave ABORT only after 2 consecutive J samples (idle line), then go to IDLE; no strobes are produced while in ABORT.
REQ-015 SHALL keep rx_valid, rx_eop and rx_err as single-cycle pulses; rx_data SHALL hold its value between strobes.

Reset
REQ-016 SHALL, on rst high at a clk48 edge, set the state to IDLE and clear all outputs to 0 (rx_data=8'h00).
REQ-017 SHALL, on reset, clear the phase counter, the ones counter and the bit counter, and set the previous sample to J.
REQ-018 SHALL apply reset asserted mid-packet on the next edge, with no strobe emitted; reception SHALL resume at the next SYNC after reset is released.

Structure
REQ-019 SHALL place in the shared package usb_pkg:
- the line-state enum (J, K, SE0, SE1);
- the rx state enum;
- the constants BIT_PERIOD=4 and STUFF_LIMIT_DEFAULT=6.
REQ-020 SHALL split out one sub-module, usb_line_sync, containing the 2-flop synchroniser and the line-state decode; everything else stays in usb_fs_rx.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- SYNC + PID 0xA5 + bytes 0x3C, 0x12 + EOP at 4 clk/bit -> rx_valid x3 with rx_data A5, 3C, 12; then rx_eop; rx_err never high.
- Byte 0xFF (stuffed 0 inserted after 6 ones) -> rx_data=FF, rx_err=0, the following byte is correct.
- Seven identical J/K samples in DATA -> rx_err pulse, rx_active=0, no rx_valid until the next SYNC.
- Bit periods alternating between 3 and 5 clocks around transitions -> all bytes received correctly (phase resync).
- rst asserted after 12 data bits -> all outputs 0 the next cycle; the next packet is received correctly.
- EOP after 11 data bits -> one rx_valid, then rx_eop and rx_err in the same cycle.
